fetcher: RTL

Instruction fetch stage of the RV32IC core. Holds the architectural fetch PC and presents it to the instruction cache. On a cache hit it captures the 16- or 32-bit instruction and forwards it to the instruction queue with a branch prediction. It computes the next PC from the instruction length, static jump decoding and a 2-bit-counter branch history table (BHT), and redirects immediately on a pipeline flush.

---
 rtl/fetcher_pkg.sv | 41 ++++
 rtl/fetcher_bht.sv | 54 +++++
 rtl/fetcher.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fetcher_pkg.sv
// Shared constants, decode helpers and types for the RV32IC fetch stage.
// Immediate extractors return the sign-extended byte offset of a control-flow instruction.
package fetcher_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] C_Q1      = 2'b01;
   localparam logic [2:0] C_F3_JAL  = 3'b001;
   localparam logic [2:0] C_F3_J    = 3'b101;
   localparam logic [2:0] C_F3_BEQZ = 3'b110;
   localparam logic [2:0] C_F3_BNEZ = 3'b111;

   localparam logic [1:0] BHT_CNT_RST = 2'b01;

   typedef enum logic [1:0] {
      K_SEQ    = 2'b00,
      K_JUMP   = 2'b01,
      K_BRANCH = 2'b10
   } cf_kind_e;

   function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] i);
      return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] i);
      return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   function automatic logic [XLEN-1:0] imm_cj(input logic [XLEN-1:0] i);
      return {{20{i[12]}}, i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
   endfunction

   function automatic logic [XLEN-1:0] imm_cb(input logic [XLEN-1:0] i);
      return {{23{i[12]}}, i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0};
   endfunction

endpackage

// File: rtl/fetcher_bht.sv
// Branch history table: 2-bit saturating counters, combinational lookup,
// synchronous update; the lookup always sees the value from before this edge's update.
module bht
   import fetcher_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam int DEPTH = 1 << IDX_W;

   logic [1:0] cnt_q [DEPTH];
   logic [1:0] cnt_d [DEPTH];
   logic [1:0] cur_s;

   assign rd_taken = cnt_q[rd_idx][1];
   assign cur_s    = cnt_q[upd_idx];

   // Saturating counter update for the resolved branch
   always_comb begin
      cnt_d = cnt_q;
      if (upd_en) begin
         if (upd_taken && (cur_s != 2'b11)) begin
            cnt_d[upd_idx] = cur_s + 2'b01;
         end else if (!upd_taken && (cur_s != 2'b00)) begin
            cnt_d[upd_idx] = cur_s - 2'b01;
         end else begin
            cnt_d[upd_idx] = cur_s;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter storage, frozen while rdy is low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            cnt_q[k] <= BHT_CNT_RST;
         end
      end else if (rdy) begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: holds the fetch PC, captures I-cache hits and
// forwards them with a static/BHT-based prediction of the next PC.
module fetcher
   import fetcher_pkg::*;
#(
   parameter int              BHT_IDX_W = 8,
   parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}}
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            flush,
   input  logic [XLEN-1:0] flush_pc,
   input  logic            iq_full,
   input  logic            icache_ready,
   input  logic [XLEN-1:0] icache_inst,
   output logic            fet_icache_enable,
   output logic [XLEN-1:0] fet_pc,
   output logic            fet_inst_valid,
   output logic [XLEN-1:0] fet_inst,
   output logic [XLEN-1:0] fet_inst_pc,
   output logic            fet_is_c,
   output logic            fet_pred_taken,
   output logic [XLEN-1:0] fet_pred_pc,
   input  logic            bp_update_en,
   input  logic [XLEN-1:0] bp_update_pc,
   input  logic            bp_update_taken
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic            is_c_q, is_c_d;
   logic            pred_taken_q, pred_taken_d;
   logic [XLEN-1:0] pred_pc_q, pred_pc_d;

   logic            is_c_s;
   logic            accept_s;
   logic            bht_taken_s;
   logic            pred_taken_s;
   logic [XLEN-1:0] seq_pc_s;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] pred_pc_s;
   cf_kind_e        kind_s;
   logic            unused_bp_pc_s;

   assign fet_icache_enable = rst && !flush && !iq_full;
   assign accept_s          = fet_icache_enable && icache_ready;
   assign is_c_s            = (icache_inst[1:0] != 2'b11);
   assign seq_pc_s          = pc_q + (is_c_s ? 32'd2 : 32'd4);
   assign unused_bp_pc_s    = ^{bp_update_pc[XLEN-1:BHT_IDX_W+1], bp_update_pc[0]};

   bht #(.IDX_W(BHT_IDX_W)) u_bht (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .rd_idx    (pc_q[BHT_IDX_W:1]),
      .rd_taken  (bht_taken_s),
      .upd_en    (bp_update_en),
      .upd_idx   (bp_update_pc[BHT_IDX_W:1]),
      .upd_taken (bp_update_taken)
   );

   // Classify the fetched word as sequential, unconditional jump or conditional branch
   always_comb begin
      kind_s = K_SEQ;
      imm_s  = 32'd0;
      if (is_c_s) begin
         if (icache_inst[1:0] == C_Q1) begin
            case (icache_inst[15:13])
               C_F3_J, C_F3_JAL: begin
                  kind_s = K_JUMP;
                  imm_s  = imm_cj(icache_inst);
               end
               C_F3_BEQZ, C_F3_BNEZ: begin
                  kind_s = K_BRANCH;
                  imm_s  = imm_cb(icache_inst);
               end
               default: kind_s = K_SEQ;
            endcase
         end else begin
            kind_s = K_SEQ;
         end
      end else begin
         case (icache_inst[6:0])
            OP_JAL: begin
               kind_s = K_JUMP;
               imm_s  = imm_j(icache_inst);
            end
            OP_BRANCH: begin
               kind_s = K_BRANCH;
               imm_s  = imm_b(icache_inst);
            end
            OP_JALR: kind_s = K_SEQ;
            default: kind_s = K_SEQ;
         endcase
      end
   end

   // Resolve the prediction into a next-PC
   always_comb begin
      case (kind_s)
         K_JUMP:   pred_taken_s = 1'b1;
         K_BRANCH: pred_taken_s = bht_taken_s;
         default:  pred_taken_s = 1'b0;
      endcase
      if (pred_taken_s) begin
         pred_pc_s = pc_q + imm_s;
      end else begin
         pred_pc_s = seq_pc_s;
      end
   end

   // Next state: flush beats a hit; a miss or a blocked queue just holds the PC
   always_comb begin
      pc_d         = pc_q;
      valid_d      = 1'b0;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      is_c_d       = is_c_q;
      pred_taken_d = pred_taken_q;
      pred_pc_d    = pred_pc_q;
      if (flush) begin
         pc_d = flush_pc;
      end else if (accept_s) begin
         pc_d         = pred_pc_s;
         valid_d      = 1'b1;
         inst_d       = icache_inst;
         inst_pc_d    = pc_q;
         is_c_d       = is_c_s;
         pred_taken_d = pred_taken_s;
         pred_pc_d    = pred_pc_s;
      end else begin
         valid_d = 1'b0;
      end
   end

   // Architectural fetch state and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q         <= RESET_PC;
         valid_q      <= 1'b0;
         inst_q       <= 32'd0;
         inst_pc_q    <= 32'd0;
         is_c_q       <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_pc_q    <= 32'd0;
      end else if (rdy) begin
         pc_q         <= pc_d;
         valid_q      <= valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         is_c_q       <= is_c_d;
         pred_taken_q <= pred_taken_d;
         pred_pc_q    <= pred_pc_d;
      end
   end

   assign fet_pc         = pc_q;
   assign fet_inst_valid = valid_q;
   assign fet_inst       = inst_q;
   assign fet_inst_pc    = inst_pc_q;
   assign fet_is_c       = is_c_q;
   assign fet_pred_taken = pred_taken_q;
   assign fet_pred_pc    = pred_pc_q;

endmodule
